// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays back the stored game sequence on the LEDs.
// On a start request it walks memory addresses 0..limite. Each value is lit
// for T_ON cycles and then blanked for T_OFF cycles. After the last element
// it pulses pronto so the play-checking unit can begin accepting moves.
// All outputs are decoded from registered state, so they never follow the
// inputs combinationally.
module exibe_sequencia #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              mostrando,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  // The timer must be able to hold the larger of the two terminal counts.
  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] T_ON_LAST  = TMR_W'(T_ON - 1);
  localparam logic [TMR_W-1:0] T_OFF_LAST = TMR_W'(T_OFF - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    AVANCA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic [ADDR_W-1:0] lim_q, lim_d;

  // State, address, timer, data and latched-limit registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      end_q    <= '0;
      tmr_q    <= '0;
      dado_q   <= '0;
      lim_q    <= '0;
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
      tmr_q    <= tmr_d;
      dado_q   <= dado_d;
      lim_q    <= lim_d;
    end
  end

  // Next-state logic. The address only advances when it is below the
  // latched limit, so it can never wrap, even with limite at all-ones.
  always_comb begin
    estado_d = estado_q;
    end_d    = end_q;
    tmr_d    = tmr_q;
    dado_d   = dado_q;
    lim_d    = lim_q;
    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          lim_d    = limite;
          end_d    = '0;
          tmr_d    = '0;
          estado_d = CARREGA;
        end else begin
          estado_d = OCIOSO;
        end
      end
      CARREGA: begin
        dado_d   = mem_dado;
        tmr_d    = '0;
        estado_d = ACENDE;
      end
      ACENDE: begin
        if (tmr_q == T_ON_LAST) begin
          tmr_d    = '0;
          estado_d = APAGA;
        end else begin
          tmr_d    = tmr_q + TMR_W'(1);
        end
      end
      APAGA: begin
        if (tmr_q == T_OFF_LAST) begin
          tmr_d = '0;
          if (end_q == lim_q) begin
            estado_d = FIM;
          end else begin
            estado_d = AVANCA;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      AVANCA: begin
        end_d    = end_q + ADDR_W'(1);
        estado_d = CARREGA;
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    leds      = '0;
    mostrando = 1'b0;
    pronto    = 1'b0;
    db_estado = 4'hF;
    case (estado_q)
      OCIOSO: begin
        db_estado = 4'd0;
      end
      CARREGA: begin
        db_estado = 4'd1;
        mostrando = 1'b1;
      end
      ACENDE: begin
        db_estado = 4'd2;
        mostrando = 1'b1;
        leds      = dado_q;
      end
      APAGA: begin
        db_estado = 4'd3;
        mostrando = 1'b1;
      end
      AVANCA: begin
        db_estado = 4'd4;
        mostrando = 1'b1;
      end
      FIM: begin
        db_estado = 4'd5;
        pronto    = 1'b1;
      end
      default: begin
        db_estado = 4'hF;
      end
    endcase
  end

  assign mem_endereco = end_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ON=3 and T_OFF=2.
// Cycle 1 is the cycle right after the edge that samples iniciar.
// Expected values come from the cycle map: each element is 1 carrega, 3 lit,
// 2 blank, plus 1 avanca if more elements follow; pronto lands at 7L+7.
module tb_exibe_sequencia;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       mostrando;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  int checks = 0;
  int errors = 0;

  exibe_sequencia #(.ADDR_W(4), .DATA_W(4), .T_ON(3), .T_OFF(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .iniciar      (iniciar),
    .limite       (limite),
    .mem_dado     (mem_dado),
    .mem_endereco (mem_endereco),
    .leds         (leds),
    .mostrando    (mostrando),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  assign mem_dado = mem[mem_endereco];

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    verifica({tag, " leds"}, 32'(leds), 32'd0);
    verifica({tag, " mostrando"}, 32'(mostrando), 32'd0);
    verifica({tag, " pronto"}, 32'(pronto), 32'd0);
    verifica({tag, " endereco"}, 32'(mem_endereco), 32'd0);
    verifica({tag, " estado"}, 32'(db_estado), 32'd0);
  endtask

  // Expected outputs in cycle c of a run with latched limit lim.
  task automatic expect_at(input int c, input int lim,
                           output logic [3:0] e_leds, output logic e_most,
                           output logic e_pronto, output logic [3:0] e_addr,
                           output logic [3:0] e_est);
    int fim_c;
    int i;
    int o;
    fim_c    = 7 * lim + 7;
    e_leds   = 4'd0;
    e_most   = 1'b0;
    e_pronto = 1'b0;
    e_addr   = 4'(lim);
    e_est    = 4'd0;
    if (c == fim_c) begin
      e_pronto = 1'b1;
      e_est    = 4'd5;
    end else if (c < fim_c) begin
      i      = (c - 1) / 7;
      o      = (c - 1) % 7;
      e_addr = 4'(i);
      e_most = 1'b1;
      if (o == 0) begin
        e_est = 4'd1;
      end else if (o <= 3) begin
        e_est  = 4'd2;
        e_leds = mem[i];
      end else if (o <= 5) begin
        e_est = 4'd3;
      end else begin
        e_est = 4'd4;
      end
    end
  endtask

  // Start a run and check every cycle up to the idle cycle after pronto.
  // poke_c: cycle in which iniciar is pulsed and limite forced to 0.
  // abort_c: cycle in which reset is asserted between clock edges.
  task automatic run_seq(input string nome, input int lim, input int poke_c,
                         input int abort_c, input bit hold);
    logic [3:0] el, ea, ee;
    logic em, ep;
    int fim_c;
    fim_c   = 7 * lim + 7;
    limite  = 4'(lim);
    iniciar = 1'b1;
    @(posedge clock); #1;
    if (!hold) iniciar = 1'b0;
    for (int c = 1; c <= fim_c + 1; c++) begin
      if (c > 1) begin
        @(posedge clock); #1;
      end
      expect_at(c, lim, el, em, ep, ea, ee);
      verifica($sformatf("%s c%0d leds", nome, c), 32'(leds), 32'(el));
      verifica($sformatf("%s c%0d mostrando", nome, c), 32'(mostrando), 32'(em));
      verifica($sformatf("%s c%0d pronto", nome, c), 32'(pronto), 32'(ep));
      verifica($sformatf("%s c%0d endereco", nome, c), 32'(mem_endereco), 32'(ea));
      verifica($sformatf("%s c%0d estado", nome, c), 32'(db_estado), 32'(ee));
      if (c == poke_c) begin
        iniciar = 1'b1;
        limite  = 4'd0;
      end else if (c == poke_c + 1) begin
        iniciar = 1'b0;
      end
      if (c == abort_c) begin
        #3 reset_n = 1'b0;
        #1 all_zero({nome, " abort"});
        for (int k = 0; k < 2; k++) begin
          @(posedge clock); #1;
          all_zero({nome, " in reset"});
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(posedge clock); #1;
          all_zero({nome, " after reset"});
        end
        return;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;

    // 1: asynchronous reset between edges clears outputs at once
    #2 reset_n = 1'b0;
    #1 all_zero("reset");
    repeat (2) @(posedge clock);
    #1 all_zero("reset held");
    reset_n = 1'b1;
    @(posedge clock); #1;
    all_zero("idle");

    // 2: single element
    mem[0] = 4'b0101;
    run_seq("single", 0, -1, -1, 1'b0);

    // 3: three elements
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4;
    run_seq("three", 2, -1, -1, 1'b0);

    // 4: iniciar and limite changes mid-sequence are ignored
    run_seq("ignored", 2, 9, -1, 1'b0);

    // 5: reset abort while element 1 is lit, then a clean restart
    run_seq("abort", 2, -1, 10, 1'b0);
    run_seq("restart", 2, -1, -1, 1'b0);

    // 6: full address range with a zero data value at address 7
    for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
    mem[7] = 4'd0;
    run_seq("full", 15, -1, -1, 1'b0);

    // 7: iniciar held high gives one idle cycle then carrega again
    mem[0] = 4'b1010;
    run_seq("b2b", 0, -1, -1, 1'b1);
    @(posedge clock); #1;
    verifica("b2b restart estado", 32'(db_estado), 32'd1);
    verifica("b2b restart endereco", 32'(mem_endereco), 32'd0);
    iniciar = 1'b0;
    #2 reset_n = 1'b0;
    #1 all_zero("final reset");
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
# exibe_sequencia

Sequence-presentation control unit for the memory game. On `iniciar` it reads the stored sequence from the game memory, address 0 up to a round limit. Each value is shown on the LEDs for `T_ON` clock cycles, followed by a blank gap of `T_OFF` cycles. It then pulses `pronto` so the play-checking control unit can start accepting `jogada` inputs. It sits beside that unit and drives the LEDs and the memory address mux while the sequence is being shown.

## Interface
- `ADDR_W`, 4: memory address width; also the width of `limite`.
- `DATA_W`, 4: memory data and LED width.
- `T_ON`, 1000: cycles each value stays lit; must be ≥1.
- `T_OFF`, 500: blank cycles after each value; must be ≥1.

- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `iniciar` in 1: start request; sampled only in `ocioso`.
- `limite` in `ADDR_W`: last address to show, inclusive; latched on accepted `iniciar`.
- `mem_dado` in `DATA_W`: memory read data. The memory is combinational-read, addressed by `mem_endereco`.
- `mem_endereco` out `ADDR_W`: address register.
- `leds` out `DATA_W`: displayed value; 0 when not lit.
- `mostrando` out 1: high in every state except `ocioso` and `fim`.
- `pronto` out 1: one-cycle pulse when the sequence is complete.
- `db_estado` out 4: state code for debug.

## Operation
The block is a Moore FSM with an internal address counter, timer and data register. `db_estado` codes are given in parentheses; any illegal state shows F and goes to `ocioso`.

- **ocioso (0):** if `iniciar`=1, latch `limite`, clear the address and timer, then go to `carrega`. Otherwise stay.
- **carrega (1):** `mem_dado` is valid for the current `mem_endereco`. Load it into the data register on the exit edge, clear the timer, go to `acende`.
- **acende (2):** `leds` shows the data register and the timer counts up. When timer = `T_ON`-1, clear the timer and go to `apaga`.
- **apaga (3):** `leds`=0 and the timer counts. When timer = `T_OFF`-1:
  - if address = latched `limite`, go to `fim`;
  - otherwise go to `avanca`.
- **avanca (4):** address +1, go to `carrega`.
- **fim (5):** `pronto`=1 for this one cycle, then go to `ocioso`.

Rules:
- `iniciar` is ignored in every state except `ocioso`.
- Changes on `limite` after acceptance have no effect on the sequence in progress.
- The timer width is `$clog2` of max(`T_ON`,`T_OFF`)+1. It never wraps during normal operation.
- The address never exceeds the latched `limite`. With `limite` = 2^`ADDR_W`-1, the address ends at the all-ones value with no wrap.
- A data value of 0 is legal; `leds` stays 0 during its `acende` window while timing proceeds normally.

## Timing
- **Reset:** while `reset_n`=0, the state is `ocioso` and the address, timer, data register and latched limit are all 0. Outputs are `leds`=0, `mem_endereco`=0, `mostrando`=0, `pronto`=0, `db_estado`=0.
- **Reset mid-operation:** asynchronous abort to the reset values, with no `pronto` pulse. After `reset_n` rises, the block waits for a new `iniciar`.
- **Start:** with `iniciar` sampled high at edge k, the FSM is in `carrega` during cycle k+1.
- **Per element:** 1 cycle `carrega`, then `T_ON` cycles lit, then `T_OFF` cycles blank. Every element except the last adds 1 cycle of `avanca`.
- **Completion:** `pronto` is high in cycle k + (L+1)(1+`T_ON`+`T_OFF`) + L + 1, where L is the latched limit. The FSM is in `ocioso` the next cycle.
- **Back-to-back:** `iniciar` held high continuously gives exactly 1 idle cycle between `pronto` and the next `carrega`.
- **Outputs:** all outputs are decoded from registered state only, so they are glitch-free with respect to the inputs.

## Test plan
All scenarios use `T_ON`=3 and `T_OFF`=2.

1. **Reset values:** `reset_n`=0 → all outputs 0 and `db_estado`=0. Assert reset asynchronously between clock edges → outputs clear immediately.
2. **Single element:** memory[0]=4'b0101, `limite`=0, `iniciar` pulse at edge 0. Required:
   - `leds`=0101 in cycles 2–4 and 0 in cycles 5–6;
   - `pronto`=1 only in cycle 7;
   - `mostrando`=1 in cycles 1–6.
3. **Three elements:** memory = {1,2,4}, `limite`=2.
   - `leds` shows 1, 2, 4 in order, each for 3 cycles with 2 blank cycles between them.
   - `mem_endereco` steps 0→1→2.
   - `pronto` occurs in cycle 21.
4. **Ignored inputs:** `iniciar` pulsed during `acende`, and `limite` changed to 0 mid-sequence → neither changes the sequence or the `pronto` timing.
5. **Reset abort:** `reset_n` asserted while `db_estado`=2 with element 1 showing → outputs go to 0 and `pronto` never pulses. A new `iniciar` then restarts from address 0.
6. **Full range with zero data:** `limite`=15 with memory[7]=0.
   - `mem_endereco` reaches 15 without wrapping.
   - `leds` stays 0 during element 7's lit window.
   - `pronto` occurs in cycle 16·6+16 = 112.
